// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run controller.
//   state_e      : controller FSM states
//   MODE_*       : run-mode encodings sampled on an accepted start
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RESET,
    RUN,
    DONE
  } state_e;

  localparam logic [1:0] MODE_FWD_OFF = 2'd0;
  localparam logic [1:0] MODE_FWD_ON  = 2'd1;
  localparam logic [1:0] MODE_COMPARE = 2'd2;

endpackage

// File: rtl/halt_detector.sv
// Flags a processor halt when the fetch PC stays unchanged for HALT_STABLE
// consecutive comparisons.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   clear    : reload prev_pc and zero the stable count; suppresses halt
//   core_pc  : observed fetch PC
//   halt     : combinational, high in the cycle the stable count reaches HALT_STABLE
module halt_detector #(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned HALT_STABLE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic [PC_W-1:0] core_pc,
  output logic            halt
);

  localparam int unsigned SW   = $clog2(HALT_STABLE + 1);
  localparam logic [SW-1:0] Last = SW'(HALT_STABLE - 1);
  localparam logic [SW-1:0] Top  = SW'(HALT_STABLE);

  logic [PC_W-1:0] prev_q;
  logic [SW-1:0]   stable_q, stable_d;
  logic            same;

  assign same = (core_pc == prev_q);

  always_comb begin
    stable_d = stable_q;
    halt     = 1'b0;
    if (clear) begin
      stable_d = '0;
    end else if (same) begin
      // Halt fires on the comparison that brings the count up to HALT_STABLE.
      if (stable_q == Last) halt = 1'b1;
      if (stable_q != Top) stable_d = stable_q + SW'(1);
    end else begin
      stable_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q   <= '0;
      stable_q <= '0;
    end else begin
      prev_q   <= core_pc;
      stable_q <= stable_d;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Sequences a processor through one or two reset/run passes and measures them.
// Optional retire counter is built when RUN_CTRL_RETIRE_COUNT_EN is defined;
// otherwise retired is tied to 0.
//   clk, rst              : clock (rising edge), asynchronous active-low reset
//   start, mode           : run request (IDLE only) and mode sampled with it
//   core_pc, core_retire  : processor fetch PC and per-cycle retire strobe
//   core_rst, forward_EN  : active-low processor reset and forwarding enable
//   busy, done, timeout   : status; done is a one-cycle pulse, timeout is sticky
//   cycles_p0, cycles_p1  : RUN cycles consumed by pass 0 / pass 1
//   retired               : retire count of the most recent pass
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned RST_CYCLES  = 5,
  parameter int unsigned MAX_CYCLES  = 100,
  parameter int unsigned HALT_STABLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [PC_W-1:0]  core_pc,
  input  logic             core_retire,
  output logic             core_rst,
  output logic             forward_EN,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles_p0,
  output logic [CNT_W-1:0] cycles_p1,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned RW = $clog2(RST_CYCLES + 1);
  localparam logic [RW-1:0]    RstLast = RW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] MaxCnt  = CNT_W'(MAX_CYCLES);

  state_e           state_q, state_d;
  logic             pass_q, pass_d;
  logic [1:0]       mode_q, mode_d;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cyc0_q, cyc0_d, cyc1_q, cyc1_d;
  logic             timeout_q, timeout_d;
  logic             enter_reset, at_budget, halt, halt_clear, fwd_sel;

  // Detector is held clear outside RUN and reloads prev_pc on the first RUN cycle.
  assign halt_clear = (state_q != RUN) || (cnt_q == CNT_W'(1));

  halt_detector #(
    .PC_W        (PC_W),
    .HALT_STABLE (HALT_STABLE)
  ) u_halt (
    .clk     (clk),
    .rst     (rst),
    .clear   (halt_clear),
    .core_pc (core_pc),
    .halt    (halt)
  );

  always_comb begin
    state_d     = state_q;
    pass_d      = pass_q;
    mode_d      = mode_q;
    rst_cnt_d   = rst_cnt_q;
    cnt_d       = cnt_q;
    cyc0_d      = cyc0_q;
    cyc1_d      = cyc1_q;
    timeout_d   = timeout_q;
    enter_reset = 1'b0;
    at_budget   = (cnt_q == MaxCnt);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Mode 3 behaves as forwarding off.
          mode_d      = (mode == MODE_FWD_ON || mode == MODE_COMPARE) ? mode : MODE_FWD_OFF;
          timeout_d   = 1'b0;
          cyc0_d      = '0;
          cyc1_d      = '0;
          cnt_d       = '0;
          pass_d      = 1'b0;
          rst_cnt_d   = '0;
          enter_reset = 1'b1;
          state_d     = RESET;
        end
      end
      RESET: begin
        if (rst_cnt_q == RstLast) begin
          cnt_d   = CNT_W'(1);
          state_d = RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      RUN: begin
        if (halt || at_budget) begin
          if (pass_q) cyc1_d = cnt_q;
          else        cyc0_d = cnt_q;
          // Halt wins a tie with the budget.
          if (!halt) timeout_d = 1'b1;
          if (mode_q == MODE_COMPARE && !pass_q) begin
            pass_d      = 1'b1;
            rst_cnt_d   = '0;
            enter_reset = 1'b1;
            state_d     = RESET;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pass_q    <= 1'b0;
      mode_q    <= MODE_FWD_OFF;
      rst_cnt_q <= '0;
      cnt_q     <= '0;
      cyc0_q    <= '0;
      cyc1_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      mode_q    <= mode_d;
      rst_cnt_q <= rst_cnt_d;
      cnt_q     <= cnt_d;
      cyc0_q    <= cyc0_d;
      cyc1_q    <= cyc1_d;
      timeout_q <= timeout_d;
    end
  end

  assign fwd_sel    = (mode_q == MODE_FWD_ON) || (mode_q == MODE_COMPARE && pass_q);
  assign forward_EN = ((state_q == RESET) || (state_q == RUN)) && fwd_sel;
  assign core_rst   = (state_q == RUN);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign timeout    = timeout_q;
  assign cycles_p0  = cyc0_q;
  assign cycles_p1  = cyc1_q;

`ifdef RUN_CTRL_RETIRE_COUNT_EN
  logic [CNT_W-1:0] retired_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_q <= '0;
    end else if (enter_reset) begin
      retired_q <= '0;
    end else if (state_q == RUN && core_retire && retired_q != '1) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign retired = retired_q;
`else
  logic unused_retire;
  assign unused_retire = core_retire ^ enter_reset;
  assign retired       = '0;
`endif

endmodule

// File: tb/tb_run_controller.sv
module tb_run_controller;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 16;
`ifdef RUN_CTRL_RETIRE_COUNT_EN
  localparam int RetExp = 7;
`else
  localparam int RetExp = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [PC_W-1:0]  core_pc = '0;
  logic             core_retire = 1'b0;
  logic             core_rst, forward_EN, busy, done, timeout;
  logic [CNT_W-1:0] cycles_p0, cycles_p1, retired;

  int   vectors = 0;
  int   miscompares = 0;
  int   rst_len [4];
  logic fwd [4];
  int   npasses, done_cnt, fwd_bad;

  always #5 clk = ~clk;

  run_controller #(
    .PC_W        (PC_W),
    .CNT_W       (CNT_W),
    .RST_CYCLES  (5),
    .MAX_CYCLES  (100),
    .HALT_STABLE (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .core_pc     (core_pc),
    .core_retire (core_retire),
    .core_rst    (core_rst),
    .forward_EN  (forward_EN),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .cycles_p0   (cycles_p0),
    .cycles_p1   (cycles_p1),
    .retired     (retired)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue a start at a negedge; returns at the following negedge.
  task automatic launch(input logic [1:0] m);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drive the processor side until the controller returns to idle. PC changes
  // for RUN cycles 1..hold_after then holds; retires on RUN cycles 1..retires of
  // pass 0. With spam, start is pulsed in RUN cycle 3 and during DONE.
  task automatic run_pass(input int hold_after, input int retires, input bit spam,
                          input int abort_pass, input int abort_k);
    int   k = 0;
    int   cur_rst = 0;
    int   pidx = 0;
    int   hv;
    logic prev_crst = 1'b0;
    rst_len  = '{default: 0};
    fwd      = '{default: 1'b0};
    npasses  = 0;
    done_cnt = 0;
    fwd_bad  = 0;
    for (int it = 0; it < 1000; it++) begin
      start = 1'b0;
      if (!busy) return;
      if (done) begin
        done_cnt++;
        if (spam) begin
          start = 1'b1;
          mode  = 2'd1;
        end
      end else if (!core_rst) begin
        cur_rst++;
      end
      if (core_rst && !prev_crst) begin
        pidx = npasses & 3;
        npasses++;
        rst_len[pidx] = cur_rst;
        cur_rst = 0;
        k = 0;
      end
      prev_crst = core_rst;
      if (core_rst) begin
        k++;
        if (k == 1) fwd[pidx] = forward_EN;
        else if (forward_EN !== fwd[pidx]) fwd_bad++;
        hv = (k <= hold_after) ? k : hold_after;
        core_pc = PC_W'(hv * 4 + pidx * 1000);
        core_retire = (k <= retires) && (pidx == 0);
        if (spam && k == 3) begin
          start = 1'b1;
          mode  = 2'd1;
        end
        if (pidx == abort_pass && k == abort_k) return;
      end else begin
        core_retire = 1'b0;
      end
      @(negedge clk);
    end
    chk("wait_bound", 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    // Reset state
    chk("rst_ctl", 64'({core_rst, forward_EN, busy, done, timeout}), 64'd0);
    chk("rst_p0", 64'(cycles_p0), 64'd0);
    chk("rst_p1", 64'(cycles_p1), 64'd0);
    chk("rst_ret", 64'(retired), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // Mode 0, halt after PC holds from RUN cycle 20
    launch(2'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_in_reset", 64'(core_rst), 64'd0);
    run_pass(20, 0, 1'b0, -1, -1);
    chk("t1_rst_len", 64'(rst_len[0]), 64'd5);
    chk("t1_passes", 64'(npasses), 64'd1);
    chk("t1_fwd", 64'(fwd[0]), 64'd0);
    chk("t1_p0", 64'(cycles_p0), 64'd24);
    chk("t1_p1", 64'(cycles_p1), 64'd0);
    chk("t1_tmo", 64'(timeout), 64'd0);
    chk("t1_done", 64'(done_cnt), 64'd1);

    // Mode 2, two passes both halting after RUN cycle 10
    launch(2'd2);
    run_pass(10, 0, 1'b0, -1, -1);
    chk("t2_passes", 64'(npasses), 64'd2);
    chk("t2_rst0", 64'(rst_len[0]), 64'd5);
    chk("t2_rst1", 64'(rst_len[1]), 64'd5);
    chk("t2_fwd0", 64'(fwd[0]), 64'd0);
    chk("t2_fwd1", 64'(fwd[1]), 64'd1);
    chk("t2_fwd_stable", 64'(fwd_bad), 64'd0);
    chk("t2_p0", 64'(cycles_p0), 64'd14);
    chk("t2_p1", 64'(cycles_p1), 64'd14);
    chk("t2_done", 64'(done_cnt), 64'd1);
    chk("t2_tmo", 64'(timeout), 64'd0);

    // Mode 1, PC never settles: budget expires
    launch(2'd1);
    run_pass(100000, 0, 1'b0, -1, -1);
    chk("t3_fwd", 64'(fwd[0]), 64'd1);
    chk("t3_p0", 64'(cycles_p0), 64'd100);
    chk("t3_tmo", 64'(timeout), 64'd1);
    chk("t3_done", 64'(done_cnt), 64'd1);
    repeat (3) @(negedge clk);
    chk("t3_tmo_sticky", 64'(timeout), 64'd1);

    // Mode 3 (as 0), halt coincides with RUN cycle 100
    launch(2'd3);
    chk("t4_tmo_clr", 64'(timeout), 64'd0);
    chk("t4_p0_clr", 64'(cycles_p0), 64'd0);
    run_pass(96, 0, 1'b0, -1, -1);
    chk("t4_fwd", 64'(fwd[0]), 64'd0);
    chk("t4_p0", 64'(cycles_p0), 64'd100);
    chk("t4_tmo", 64'(timeout), 64'd0);

    // Mode 0 with starts while busy and during DONE, 7 retires
    launch(2'd0);
    run_pass(20, 7, 1'b1, -1, -1);
    chk("t5_passes", 64'(npasses), 64'd1);
    chk("t5_fwd", 64'(fwd[0]), 64'd0);
    chk("t5_fwd_stable", 64'(fwd_bad), 64'd0);
    chk("t5_p0", 64'(cycles_p0), 64'd24);
    chk("t5_done", 64'(done_cnt), 64'd1);
    chk("t5_ret", 64'(retired), 64'(RetExp));
    @(negedge clk);
    chk("t5_idle", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of pass 1 of mode 2
    launch(2'd2);
    run_pass(10, 0, 1'b0, 1, 5);
    chk("t6_pre_fwd", 64'(forward_EN), 64'd1);
    chk("t6_pre_p0", 64'(cycles_p0), 64'd14);
    rst = 1'b0;
    #1;
    chk("t6_ctl", 64'({core_rst, forward_EN, busy, done, timeout}), 64'd0);
    chk("t6_p0", 64'(cycles_p0), 64'd0);
    chk("t6_p1", 64'(cycles_p1), 64'd0);
    chk("t6_ret", 64'(retired), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    core_retire = 1'b0;
    @(negedge clk);
    chk("t6_idle", 64'(busy), 64'd0);

    // Fresh run after the abort
    launch(2'd0);
    run_pass(20, 0, 1'b0, -1, -1);
    chk("t7_rst_len", 64'(rst_len[0]), 64'd5);
    chk("t7_fwd", 64'(fwd[0]), 64'd0);
    chk("t7_p0", 64'(cycles_p0), 64'd24);
    chk("t7_p1", 64'(cycles_p1), 64'd0);
    chk("t7_done", 64'(done_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter PC_W, 32, width of the observed core program counter.
REQ-002 Parameter CNT_W, 16, width of all cycle and retire counters.
REQ-003 Parameter RST_CYCLES, 5, number of cycles core reset is held asserted per pass (>=1).
REQ-004 Parameter MAX_CYCLES, 100, RUN-cycle budget per pass before timeout (>=2, < 2^CNT_W).
REQ-005 Parameter HALT_STABLE, 4, consecutive unchanged-PC cycles that constitute a halt (>=1).
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  one-cycle request to begin a run; ignored unless idle.
REQ-009 mode  input  2  0=forwarding off, 1=forwarding on, 2=two passes (off then on), 3=treated as 0; sampled only on accepted start.
REQ-010 core_pc  input  PC_W  processor fetch PC.
REQ-011 core_retire  input  1  processor retired one instruction this cycle.
REQ-012 core_rst  output  1  active-low reset driven to the processor.
REQ-013 forward_EN  output  1  forwarding enable driven to the processor.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse when the run completes.
REQ-016 timeout  output  1  sticky: the last pass ended on budget; cleared on accepted start.
REQ-017 cycles_p0, cycles_p1  output  CNT_W each  RUN cycles consumed by pass 0 / pass 1.
REQ-018 retired  output  CNT_W  retire count of the most recent pass.

Function
REQ-019 FSM states SHALL be IDLE, RESET, RUN, DONE; the pass index (0/1) SHALL be a separate register.
REQ-020 IDLE: core_rst=0; start=1 SHALL latch mode, clear timeout, cycles_p0, cycles_p1 and retired, set pass=0, and go to RESET.
REQ-021 forward_EN SHALL be 1 for mode 1, or for mode 2 with pass=1, else 0; stable from RESET entry to pass end.
REQ-022 RESET: core_rst=0 for exactly RST_CYCLES cycles, then RUN.
REQ-023 RUN: core_rst=1; cycle counter starts at 1 in the first RUN cycle and increments each RUN cycle.
REQ-024 Halt detector: first RUN cycle loads prev_pc and clears stable count; thereafter core_pc==prev_pc increments stable, otherwise clears it; prev_pc updates every cycle.
REQ-025 Halt SHALL be flagged in the cycle the stable count reaches HALT_STABLE; timeout in the cycle the cycle counter equals MAX_CYCLES.
REQ-026 Simultaneous halt and timeout: halt wins, timeout stays 0.
REQ-027 Pass end: the current cycle count SHALL be stored to cycles_p0 or cycles_p1 per pass index; timeout is set if the pass ended on budget.
REQ-028 After pass end: mode 2 with pass=0 SHALL set pass=1 and re-enter RESET; otherwise go to DONE.
REQ-029 DONE: done=1 for exactly one cycle, core_rst=0, then IDLE; a start during DONE is ignored.
REQ-030 start while busy SHALL have no effect.
REQ-031 retired SHALL clear on RESET entry and increment on core_retire in RUN, saturating at all-ones.

Reset
REQ-032 rst low SHALL asynchronously force IDLE, pass=0, core_rst=0, forward_EN=0, busy=0, done=0, timeout=0, and all counters and stored values to 0, including mid-run.

Configuration
REQ-033 Macro RUN_CTRL_RETIRE_COUNT_EN: when defined, the retire counter of REQ-031 is built; when undefined, retired SHALL be constant 0, core_retire is unused, and no counter logic is present.

Structure
REQ-034 Shared package run_ctrl_pkg SHALL hold the state enum and the mode constants (MODE_FWD_OFF, MODE_FWD_ON, MODE_COMPARE).
REQ-035 The PC-stable logic SHALL be a sub-module halt_detector (inputs clk, rst, clear, core_pc; output halt; parameters PC_W, HALT_STABLE).

Verification (RST_CYCLES=5, MAX_CYCLES=100, HALT_STABLE=4)
REQ-036 mode 0, PC changes for RUN cycles 1-20 then holds -> core_rst low 5 cycles, forward_EN=0, cycles_p0=24, timeout=0, done pulses once.
REQ-037 mode 2, PC holds after RUN cycle 10 in both passes -> two 5-cycle resets, forward_EN 0 then 1, cycles_p0=cycles_p1=14, single done.
REQ-038 mode 1, PC always changing -> cycles_p0=100, timeout=1, forward_EN=1.
REQ-039 PC stabilises so the halt lands on RUN cycle 100 -> timeout=0, cycles_p0=100.
REQ-040 rst pulsed low mid-RUN of pass 1 -> all outputs 0 immediately; a later start behaves as fresh.
REQ-041 start repeated while busy, and 7 retires in pass -> ignored start; retired=7 with macro, 0 without.
